// File: rtl/prbs_multi_generator_if.sv
// prbs_multi_generator_if: control and serial-output bundle between the PRBS source and its users.
interface prbs_multi_generator_if #(
  parameter int DIV_WIDTH = 16
);
  logic                 enable;
  logic [2:0]           poly_sel;
  logic [DIV_WIDTH-1:0] div_period;
  logic                 seed_load;
  logic [30:0]          seed;
  logic                 invert;
  logic                 err_inject;
  logic                 data_out;
  logic                 bit_valid;
  logic                 bit_clock;
  logic                 seq_start;
  modport master (
    output enable, poly_sel, div_period, seed_load, seed, invert, err_inject,
    input  data_out, bit_valid, bit_clock, seq_start
  );
  modport slave (
    input  enable, poly_sel, div_period, seed_load, seed, invert, err_inject,
    output data_out, bit_valid, bit_clock, seq_start
  );
endinterface

// File: rtl/prbs_multi_generator.sv
// prbs_multi_generator: runtime-selectable PRBS-7/9/15/23/31 source with bit-rate divider,
// seed load, inversion, single-bit error injection and a sequence-start marker.
module prbs_multi_generator #(
  parameter int         DIV_WIDTH  = 16,
  parameter logic [2:0] RESET_POLY = 3'd2
) (
  input  logic clk,
  input  logic reset_n,
  prbs_multi_generator_if.slave bus
);
  logic [30:0]          lfsr_q, lfsr_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           poly_q, poly_d;
  logic                 data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 bclk_q, bclk_d;
  logic                 seq_q, seq_d;
  logic                 err_q, err_d;
  logic [4:0]           n_m1, tap_m1;
  logic [30:0]          mask, shifted, seed_m;
  logic [DIV_WIDTH-1:0] per_m1;
  logic                 tick, out_raw, fb;
  always_comb begin
    n_m1    = poly_q == 3'd0 ? 5'd6 : poly_q == 3'd1 ? 5'd8 : poly_q == 3'd3 ? 5'd22 :
              poly_q == 3'd4 ? 5'd30 : 5'd14;
    tap_m1  = poly_q == 3'd0 ? 5'd5 : poly_q == 3'd1 ? 5'd4 : poly_q == 3'd3 ? 5'd17 :
              poly_q == 3'd4 ? 5'd27 : 5'd13;
    mask    = 31'h7FFF_FFFF >> (5'd30 - n_m1);
    out_raw = lfsr_q[n_m1];
    fb      = out_raw ^ lfsr_q[tap_m1];
    shifted = {lfsr_q[29:0], fb} & mask;
    seed_m  = bus.seed & mask;
    // div_period of 0 behaves like 1; a shrink below the running count ticks on the next clock
    per_m1  = bus.div_period == '0 ? '0 : bus.div_period - DIV_WIDTH'(1);
    tick    = bus.enable && !bus.seed_load && cnt_q >= per_m1;
    poly_d  = bus.enable ? poly_q : bus.poly_sel;
    cnt_d   = (bus.seed_load || !bus.enable || tick) ? '0 : cnt_q + DIV_WIDTH'(1);
    lfsr_d  = bus.seed_load ? (seed_m == '0 ? 31'h1 : seed_m) : tick ? shifted : lfsr_q;
    data_d  = tick ? out_raw ^ bus.invert ^ err_q : data_q;
    valid_d = tick;
    bclk_d  = bclk_q ^ tick;
    seq_d   = tick && (lfsr_q & mask) == 31'h1;
    // a pulse coincident with a tick is kept for the following bit
    err_d   = bus.err_inject || (err_q && !tick);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q  <= 31'h1;
      cnt_q   <= '0;
      poly_q  <= RESET_POLY;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      bclk_q  <= 1'b0;
      seq_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      poly_q  <= poly_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      bclk_q  <= bclk_d;
      seq_q   <= seq_d;
      err_q   <= err_d;
    end
  end
  assign bus.data_out  = data_q;
  assign bus.bit_valid = valid_q;
  assign bus.bit_clock = bclk_q;
  assign bus.seq_start = seq_q;
endmodule

// File: tb/tb_prbs_multi_generator.sv
// tb_prbs_multi_generator: scoreboard bench; a software LFSR queues expected bits, the monitor pops them on bit_valid.
module tb_prbs_multi_generator;
  localparam int DW = 16;
  typedef struct packed {logic d; logic s;} exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #10 clk = ~clk;
  prbs_multi_generator_if #(.DIV_WIDTH(DW)) bus ();
  prbs_multi_generator #(.DIV_WIDTH(DW), .RESET_POLY(3'd2)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  exp_t q[$];
  int seq_idx[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, en_cyc = 0, nbits = 0, ones = 0, nseq = 0, first_cyc = -1, last_cyc = 0, exp_gap = 0;
  logic bclk_exp = 1'b0;
  logic [7:0] first8 = '0;
  logic [30:0] m_lfsr = 31'h1;
  int m_n = 15, m_tap = 14;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (bus.bit_valid) begin
      bclk_exp = ~bclk_exp;
      chk("bit_clock", bus.bit_clock, bclk_exp);
      if (exp_gap != 0 && first_cyc >= 0) chk("gap", cyc - last_cyc, exp_gap);
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      if (nbits < 8) first8[nbits] = bus.data_out;
      ones += int'(bus.data_out);
      if (bus.seq_start) begin
        nseq++;
        seq_idx.push_back(nbits);
      end
      nbits++;
      if (q.size() == 0) chk("extra_bit", 1, 0);
      else begin
        e = q.pop_front();
        chk("data", bus.data_out, e.d);
        chk("seq_start", bus.seq_start, e.s);
      end
    end
  end
  task automatic set_poly(input int p);
    m_n   = p == 0 ? 7 : p == 1 ? 9 : p == 3 ? 23 : p == 4 ? 31 : 15;
    m_tap = p == 0 ? 6 : p == 1 ? 5 : p == 3 ? 18 : p == 4 ? 28 : 14;
  endtask
  task automatic push_bits(input int n, input int err_at, input logic inv);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      logic raw;
      logic [30:0] m;
      m = (31'h1 << m_n) - 31'h1;
      raw = m_lfsr[m_n-1];
      e.s = (m_lfsr == 31'h1);
      e.d = raw ^ inv ^ (i == err_at);
      q.push_back(e);
      m_lfsr = {m_lfsr[29:0], raw ^ m_lfsr[m_tap-1]} & m;
    end
  endtask
  task automatic clear_stats();
    nbits = 0; ones = 0; nseq = 0; first_cyc = -1; first8 = '0;
    seq_idx.delete();
  endtask
  task automatic select(input int p);
    bus.enable = 1'b0;
    bus.poly_sel = 3'(p);
    @(negedge clk);
    set_poly(p);
  endtask
  task automatic load(input logic [30:0] s);
    logic [30:0] m;
    m = (31'h1 << m_n) - 31'h1;
    bus.seed = s;
    bus.seed_load = 1'b1;
    @(negedge clk);
    bus.seed_load = 1'b0;
    m_lfsr = (s & m) == '0 ? 31'h1 : s & m;
  endtask
  task automatic start(input int div, input logic inv);
    bus.div_period = DW'(div);
    bus.invert = inv;
    bus.enable = 1'b1;
    en_cyc = cyc;
  endtask
  task automatic wait_bits(input int n, input int budget);
    int k = 0;
    while (nbits < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (nbits < n) chk("wait_timeout", nbits, n);
  endtask
  task automatic drain(input int budget);
    int k = 0;
    while (q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
    bus.enable = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    bus.enable = 1'b0; bus.poly_sel = 3'd0; bus.div_period = DW'(1); bus.seed_load = 1'b0;
    bus.seed = '0; bus.invert = 1'b0; bus.err_inject = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", bus.data_out, 0);
    chk("rst_valid", bus.bit_valid, 0);
    chk("rst_bclk", bus.bit_clock, 0);
    chk("rst_seq", bus.seq_start, 0);
    reset_n = 1'b1;
    // PRBS-7 from the reset state, one bit per clock
    select(0);
    m_lfsr = 31'h1;
    clear_stats();
    push_bits(254, -1, 1'b0);
    start(1, 1'b0);
    drain(400);
    chk("p7_latency", first_cyc - en_cyc, 1);
    chk("p7_first8", first8, 8'b0100_0000);
    chk("p7_nseq", nseq, 2);
    chk("p7_seq_period", seq_idx.size() >= 2 ? seq_idx[1] - seq_idx[0] : -1, 127);
    chk("p7_ones", ones, 128);
    // PRBS-15 with a 500-clock bit period, then a full period at full rate
    select(2);
    clear_stats();
    exp_gap = 500;
    push_bits(20, -1, 1'b0);
    start(500, 1'b0);
    drain(20 * 500 + 100);
    exp_gap = 0;
    chk("p15_latency", first_cyc - en_cyc, 500);
    clear_stats();
    exp_gap = 1;
    push_bits(32767, -1, 1'b0);
    start(1, 1'b0);
    drain(33000);
    exp_gap = 0;
    chk("p15_ones", ones, 16384);
    chk("p15_nseq", nseq, 1);
    // PRBS-9 seq_start spacing
    select(1);
    load(31'h1);
    clear_stats();
    push_bits(1100, -1, 1'b0);
    start(1, 1'b0);
    drain(1300);
    chk("p9_nseq", nseq, 3);
    chk("p9_seq_period", seq_idx.size() >= 2 ? seq_idx[1] - seq_idx[0] : -1, 511);
    // PRBS-23 and PRBS-31 against the model from random seeds
    select(3);
    load(31'($urandom));
    clear_stats();
    push_bits(3000, -1, 1'b0);
    start(2, 1'b0);
    drain(6500);
    select(4);
    load(31'($urandom));
    clear_stats();
    push_bits(4000, -1, 1'b0);
    start(1, 1'b0);
    drain(4500);
    // error injection: two pulses before one tick flip a single bit
    select(2);
    clear_stats();
    push_bits(60, 20, 1'b0);
    start(3, 1'b0);
    wait_bits(20, 200);
    bus.err_inject = 1'b1;
    repeat (2) @(negedge clk);
    bus.err_inject = 1'b0;
    drain(300);
    // inverted stream; a pulse coincident with a tick hits the following bit
    clear_stats();
    push_bits(60, 21, 1'b1);
    start(1, 1'b1);
    wait_bits(20, 100);
    bus.err_inject = 1'b1;
    @(negedge clk);
    bus.err_inject = 1'b0;
    drain(200);
    bus.invert = 1'b0;
    // zero seed becomes 1 and marks a sequence start
    load(31'h0);
    clear_stats();
    push_bits(5, -1, 1'b0);
    start(1, 1'b0);
    drain(50);
    chk("seed0_seq_first", seq_idx.size() >= 1 ? seq_idx[0] : -1, 0);
    // all-ones seed; poly_sel moved while running must not matter
    load(31'h7FFF);
    clear_stats();
    push_bits(200, -1, 1'b0);
    start(1, 1'b0);
    repeat (5) @(negedge clk);
    bus.poly_sel = 3'd0;
    drain(300);
    chk("seed7fff_first", first8[0], 1);
    // reset mid-bit clears outputs at once, then the sequence restarts from 1 under RESET_POLY
    select(2);
    load(31'h7FFF);
    clear_stats();
    push_bits(1, -1, 1'b0);
    start(10, 1'b0);
    wait_bits(1, 50);
    repeat (3) @(negedge clk);
    chk("pre_rst_data", bus.data_out, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_data", bus.data_out, 0);
    chk("mid_rst_valid", bus.bit_valid, 0);
    chk("mid_rst_bclk", bus.bit_clock, 0);
    chk("mid_rst_seq", bus.seq_start, 0);
    bus.enable = 1'b0;
    bclk_exp = 1'b0;
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    bus.poly_sel = 3'd0;
    set_poly(2);
    m_lfsr = 31'h1;
    clear_stats();
    push_bits(100, -1, 1'b0);
    start(1, 1'b0);
    drain(200);
    chk("post_rst_latency", first_cyc - en_cyc, 1);
    chk("post_rst_seq_first", seq_idx.size() >= 1 ? seq_idx[0] : -1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
